// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the FPGA top level.
// It pulses the DDR controller reset, then waits for PLL lock and DDR calibration.
// After that it releases the active-low domain resets one at a time, bit 0 first.
// Losing lock, a soft reset request while running, or a calibration timeout
// starts the whole sequence again from the power-on pulse.
module rst_seq_ctrl #(
  parameter int NUM_OUT       = 3,
  parameter int POR_CYCLES    = 1000,
  parameter int STAGE_GAP     = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int CALIB_TIMEOUT = 1048576,
  parameter int CNT_WIDTH     = 32
) (
  input  logic               CLK,
  input  logic               rst_x_async,
  input  logic               i_locked,
  input  logic               i_calib_done,
  input  logic               i_soft_rst,
  output logic               o_sys_rst,
  output logic [NUM_OUT-1:0] o_rst_x,
  output logic               o_ready,
  output logic [2:0]         o_state,
  output logic               o_calib_timeout
);

  localparam logic [2:0] S_POR        = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_WAIT_CALIB = 3'd2;
  localparam logic [2:0] S_RELEASE    = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;
  localparam logic [2:0] S_FAULT      = 3'd5;

  localparam logic [CNT_WIDTH-1:0] POR_LAST   = CNT_WIDTH'(POR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CALIB_LAST = CNT_WIDTH'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] REL_LAST   = CNT_WIDTH'(STAGE_GAP * NUM_OUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [2:0]             state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [SYNC_STAGES-1:0] lk_sync;
  logic [SYNC_STAGES-1:0] cd_sync;
  logic                   lk;
  logic                   cd;
  logic                   abort;
  logic [NUM_OUT-1:0]     release_hit;

  assign lk      = lk_sync[SYNC_STAGES-1];
  assign cd      = cd_sync[SYNC_STAGES-1];
  assign o_state = state;

  // Bring the asynchronous lock and calibration flags into the CLK domain.
  always_ff @(posedge CLK or negedge rst_x_async) begin
    if (!rst_x_async) begin
      lk_sync <= '0;
      cd_sync <= '0;
    end else begin
      lk_sync <= {lk_sync[SYNC_STAGES-2:0], i_locked};
      cd_sync <= {cd_sync[SYNC_STAGES-2:0], i_calib_done};
    end
  end

  // Restart the sequence if lock is lost after it was first seen, or on a soft request while running.
  always_comb begin
    abort = 1'b0;
    if (!lk && (state == S_WAIT_CALIB || state == S_RELEASE || state == S_RUN))
      abort = 1'b1;
    if (i_soft_rst && state == S_RUN)
      abort = 1'b1;
  end

  // A domain's bit is due when the release counter reaches the end of that bit's gap.
  always_comb begin
    release_hit = '0;
    for (int k = 0; k < NUM_OUT; k++)
      release_hit[k] = (cnt == CNT_WIDTH'(STAGE_GAP * (k + 1) - 1));
  end

  // Sequencer FSM: one shared counter times the POR pulse, calibration wait and release gaps.
  always_ff @(posedge CLK or negedge rst_x_async) begin
    if (!rst_x_async) begin
      state           <= S_POR;
      cnt             <= '0;
      o_sys_rst       <= 1'b1;
      o_rst_x         <= '0;
      o_ready         <= 1'b0;
      o_calib_timeout <= 1'b0;
    end else if (abort) begin
      state     <= S_POR;
      cnt       <= '0;
      o_sys_rst <= 1'b1;
      o_rst_x   <= '0;
      o_ready   <= 1'b0;
    end else begin
      case (state)
        S_POR: begin
          if (cnt == POR_LAST) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            o_sys_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          cnt <= '0;
          if (lk)
            state <= S_WAIT_CALIB;
        end
        S_WAIT_CALIB: begin
          if (cd) begin
            state <= S_RELEASE;
            cnt   <= '0;
          end else if (cnt == CALIB_LAST) begin
            state           <= S_FAULT;
            cnt             <= '0;
            o_calib_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RELEASE: begin
          cnt     <= cnt + CNT_ONE;
          o_rst_x <= o_rst_x | release_hit;
          if (cnt == REL_LAST) begin
            state   <= S_RUN;
            cnt     <= '0;
            o_ready <= 1'b1;
          end
        end
        S_RUN: begin
          cnt <= '0;
        end
        S_FAULT: begin
          state     <= S_POR;
          cnt       <= '0;
          o_sys_rst <= 1'b1;
        end
        default: begin
          state     <= S_POR;
          cnt       <= '0;
          o_sys_rst <= 1'b1;
          o_rst_x   <= '0;
          o_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
